// File: rtl/breed_pop.sv
// Next-population builder: copies the N_SEL selected parents, then emits one
// LFSR-driven single-point crossover child per clock. BREED_MUTATION_EN adds a per-child bit flip.
module breed_pop #(
  parameter int unsigned N_SEL  = 10,
  parameter int unsigned N_POP  = 50,
  parameter int unsigned IND_W  = 150,
  parameter int unsigned GENE_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [15:0]              seed,
  input  logic [N_SEL*IND_W-1:0]   sel_pop,
  output logic [N_POP*IND_W-1:0]   pop_out,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned N_GENES   = IND_W / GENE_W;
  localparam int unsigned K_W       = $clog2(N_POP + 1);
  localparam logic [15:0] LFSR_INIT = 16'hACE1;

  typedef enum logic [1:0] {IDLE, COPY, BREED, DONE} state_t;

  state_t                 state;
  logic [N_SEL*IND_W-1:0] par_q;
  logic [15:0]            lfsr;
  logic [15:0]            lfsr_next;
  logic [K_W-1:0]         k;
  logic [7:0]             a_idx;
  logic [7:0]             b_idx;
  logic [7:0]             cut;
  logic [IND_W-1:0]       child;
`ifdef BREED_MUTATION_EN
  logic [7:0]             mut_bit;
`endif

  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  // Parent pick and gene-aligned cut point from the current LFSR value.
  always_comb begin
    a_idx = lfsr[7:0] % 8'(N_SEL);
    b_idx = lfsr[15:8] % 8'(N_SEL);
    cut   = ((lfsr[7:0] ^ lfsr[15:8]) % 8'(N_GENES - 1)) + 8'd1;
    child = '0;
    for (int g = 0; g < int'(N_GENES); g++) begin
      if (g < int'(cut))
        child[g*GENE_W +: GENE_W] = par_q[int'(a_idx)*IND_W + g*GENE_W +: GENE_W];
      else
        child[g*GENE_W +: GENE_W] = par_q[int'(b_idx)*IND_W + g*GENE_W +: GENE_W];
    end
`ifdef BREED_MUTATION_EN
    mut_bit = (lfsr[11:4] ^ lfsr[15:8]) % 8'(IND_W);
    if (lfsr[3:0] == 4'd0)
      child[mut_bit] = ~child[mut_bit];
`endif
  end

  // Pass sequencer: IDLE -> COPY -> BREED (one child per cycle) -> DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pop_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      lfsr    <= LFSR_INIT;
      k       <= '0;
      par_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            par_q <= sel_pop;
            lfsr  <= (seed == 16'd0) ? LFSR_INIT : seed;
            busy  <= 1'b1;
            state <= COPY;
          end
        end
        COPY: begin
          pop_out[N_SEL*IND_W-1:0] <= par_q;
          k     <= K_W'(N_SEL);
          state <= BREED;
        end
        BREED: begin
          pop_out[int'(k)*IND_W +: IND_W] <= child;
          lfsr <= lfsr_next;
          k    <= k + K_W'(1);
          if (k == K_W'(N_POP - 1)) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_breed_pop.sv
// Scoreboard bench for breed_pop: stimulus pushes golden populations, a monitor
// compares them whenever done pulses. Honours BREED_MUTATION_EN in its model.
module tb_breed_pop;

  localparam int NSEL   = 10;
  localparam int NPOP   = 50;
  localparam int IND_W  = 150;
  localparam int GENE_W = 6;
  localparam int NGENES = IND_W / GENE_W;
  localparam int SELW   = NSEL * IND_W;
  localparam int POPW   = NPOP * IND_W;
  localparam int LAT    = NPOP - NSEL + 2;

  typedef struct {
    logic [POPW-1:0] pop;
    int              done_cyc;
  } exp_t;

  logic            clk;
  logic            rst;
  logic            start;
  logic [15:0]     seed;
  logic [SELW-1:0] sel_pop;
  logic [POPW-1:0] pop_out;
  logic            busy;
  logic            done;

  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;
  exp_t sb[$];

  logic [SELW-1:0]  par1, par2, par0;
  logic [IND_W-1:0] hand;
  logic [POPW-1:0]  gold_tmp;

  breed_pop dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .sel_pop(sel_pop), .pop_out(pop_out), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [POPW-1:0] golden(input logic [SELW-1:0] par, input logic [15:0] sd);
    logic [POPW-1:0]  res;
    logic [15:0]      l;
    logic [IND_W-1:0] ch;
    int a, b, c;
    res = '0;
    res[SELW-1:0] = par;
    l = sd;
    for (int s = NSEL; s < NPOP; s++) begin
      a = int'(l[7:0]) % NSEL;
      b = int'(l[15:8]) % NSEL;
      c = int'(l[7:0] ^ l[15:8]) % (NGENES - 1) + 1;
      for (int j = 0; j < IND_W; j++)
        ch[j] = (j < c * GENE_W) ? par[a*IND_W + j] : par[b*IND_W + j];
`ifdef BREED_MUTATION_EN
      if (l[3:0] == 4'd0) begin
        int m;
        m = int'(l[11:4] ^ l[15:8]) % IND_W;
        ch[m] = ~ch[m];
      end
`endif
      res[s*IND_W +: IND_W] = ch;
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    return res;
  endfunction

  task automatic chk(input string nm, input logic [IND_W-1:0] act, input logic [IND_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic mon_step();
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL spurious_done: done=1 at cycle %0d, expected 0", cyc);
      end else begin
        e = sb.pop_front();
        vectors++;
        if (cyc != e.done_cyc) begin
          errors++;
          $display("FAIL done_cycle: got %0d, expected %0d", cyc, e.done_cyc);
        end
        for (int s = 0; s < NPOP; s++) begin
          vectors++;
          if (pop_out[s*IND_W +: IND_W] !== e.pop[s*IND_W +: IND_W]) begin
            errors++;
            $display("FAIL slot%0d: got %h, expected %h", s,
                     pop_out[s*IND_W +: IND_W], e.pop[s*IND_W +: IND_W]);
          end
        end
      end
    end
  endtask

  task automatic start_pass(input logic [SELW-1:0] par, input logic [15:0] sd,
                            input bit push_exp, input logic [POPW-1:0] gold);
    exp_t e;
    @(negedge clk);
    sel_pop = par;
    seed    = sd;
    start   = 1'b1;
    if (push_exp) begin
      e.pop      = gold;
      e.done_cyc = cyc + 1 + LAT;
      sb.push_back(e);
    end
    @(negedge clk);
    start   = 1'b0;
    sel_pop = ~par;
    seed    = 16'h0F0F;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) return;
    end
    vectors++;
    errors++;
    $display("FAIL done_timeout: no done within %0d cycles, expected a pulse", budget);
  endtask

  task automatic shape_check();
    int trans, pos;
    logic [IND_W-1:0] ch;
    for (int s = NSEL; s < NPOP; s++) begin
      ch = pop_out[s*IND_W +: IND_W];
      trans = 0;
      pos = 0;
      for (int j = 1; j < IND_W; j++)
        if (ch[j] != ch[j-1]) begin
          trans++;
          pos = j;
        end
      vectors++;
      if (trans > 1 || (trans == 1 && (pos % GENE_W != 0 || pos < GENE_W || pos > IND_W - GENE_W))) begin
        errors++;
        $display("FAIL shape_slot%0d: got %0d transitions at bit %0d, expected <=1 on a gene boundary",
                 s, trans, pos);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; seed = '0; sel_pop = '0;
    for (int i = 0; i < NSEL; i++)
      for (int g = 0; g < NGENES; g++)
        par1[i*IND_W + g*GENE_W +: GENE_W] = 6'(i + 1);
    for (int i = 0; i < NSEL; i++)
      par2[i*IND_W +: IND_W] = (i % 2 == 1) ? {IND_W{1'b1}} : {IND_W{1'b0}};
    par0 = '0;
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
      begin
        repeat (3) @(negedge clk);
        chk("reset_pop", IND_W'(|pop_out), '0);
        chk("reset_busy", IND_W'(busy), '0);
        chk("reset_done", IND_W'(done), '0);
        rst = 1'b0;

        // Elitism plus hand-computed first child (a=2, b=8, cut after 15 genes).
        start_pass(par1, 16'h1234, 1'b1, golden(par1, 16'h1234));
        @(negedge clk);
        chk("busy_in_pass", IND_W'(busy), IND_W'(1));
        wait_done(LAT + 5);
        hand = {{10{6'd9}}, {15{6'd3}}};
        chk("hand_slot10", pop_out[10*IND_W +: IND_W], hand);
        for (int i = 0; i < NSEL; i++)
          chk($sformatf("elite%0d", i), pop_out[i*IND_W +: IND_W], par1[i*IND_W +: IND_W]);
        @(negedge clk);
        chk("done_one_cycle", IND_W'(done), '0);
        chk("busy_after_done", IND_W'(busy), '0);

        // Crossover shape with complementary parents.
        start_pass(par2, 16'h00FF, 1'b1, golden(par2, 16'h00FF));
        wait_done(LAT + 5);
`ifndef BREED_MUTATION_EN
        shape_check();
`endif

        // Zero seed behaves as the default seed.
        start_pass(par1, 16'h0000, 1'b1, golden(par1, 16'hACE1));
        wait_done(LAT + 5);

        // Extra start pulses mid-pass are ignored.
        start_pass(par2, 16'h00FF, 1'b1, golden(par2, 16'h00FF));
        for (int i = 2; i <= LAT - 1; i++) begin
          start = (i == 5 || i == 20);
          seed  = 16'h5555;
          @(negedge clk);
        end
        start = 1'b0;
        wait_done(10);

        // Reset mid-pass, then a clean rerun.
        start_pass(par1, 16'hBEEF, 1'b0, '0);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_pop", IND_W'(|pop_out), '0);
        chk("abort_busy", IND_W'(busy), '0);
        chk("abort_done", IND_W'(done), '0);
        rst = 1'b0;
        start_pass(par1, 16'hBEEF, 1'b1, golden(par1, 16'hBEEF));
        wait_done(LAT + 5);

        // All-zero parents: only mutation can set bits.
        gold_tmp = golden(par0, 16'hACE1);
        start_pass(par0, 16'hACE1, 1'b1, gold_tmp);
        wait_done(LAT + 5);
`ifndef BREED_MUTATION_EN
        chk("zero_parents_pop", IND_W'(|pop_out), '0);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", IND_W'(sb.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
      end
    join_any
  end

endmodule

// File: doc/breed_pop.md
Name: breed_pop

Overview:
- Downstream stage of the selection block. Consumes the 10 selected individuals (sel_pop, 10 x 150 bits) and builds the next 50-individual population (7500 bits) for the next distance/sort pass.
- Slots 0..N_SEL-1 copy the parents unchanged (elitism).
- Each remaining slot is a single-point, gene-aligned crossover of two LFSR-chosen parents, produced one child per clock.

Parameters:
N_SEL, 10, number of parent individuals in sel_pop
N_POP, 50, number of individuals in pop_out
IND_W, 150, bits per individual
GENE_W, 6, bits per gene; IND_W must be a multiple of GENE_W (N_GENES = IND_W/GENE_W = 25)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin a breed pass; sampled only in IDLE
seed  in  16  LFSR seed, loaded when start is accepted
sel_pop  in  N_SEL*IND_W  parents; individual i at [IND_W*i +: IND_W]
pop_out  out  N_POP*IND_W  next population, registered; individual k at [IND_W*k +: IND_W]
busy  out  1  high in COPY and BREED
done  out  1  one-cycle pulse in DONE

Behaviour:
- Interface: one clock, clk. Reset is rst: synchronous, active-high.
- Reset values: pop_out=0, done=0, busy=0, state=IDLE, lfsr=16'hACE1, child counter k=0.
- Reset mid-pass: abandons the pass. pop_out is cleared. Any partial result is discarded.
- States:
  - IDLE: if start, latch sel_pop into an internal parent register. Load lfsr=seed, or 16'hACE1 if seed==0. Go to COPY.
  - COPY (1 cycle): pop_out slots 0..N_SEL-1 <= parent slots 0..N_SEL-1. Set k=N_SEL. Go to BREED.
  - BREED: each cycle write slot k, advance lfsr, k<=k+1. When slot N_POP-1 is written, go to DONE.
  - DONE (1 cycle): done=1. Go to IDLE.
- Latency: start is sampled high at edge 0; done is high during the cycle after edge N_POP-N_SEL+2 (42 with defaults).
- pop_out holds its value from DONE until the next accepted start or reset. Slots not yet written keep their previous contents.
- start in any state other than IDLE is ignored. sel_pop changes after start is accepted have no effect.
- LFSR: 16-bit Fibonacci. lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}, advanced once per BREED cycle only.
- Per BREED cycle, using the current lfsr value L:
  - a = L[7:0] % N_SEL
  - b = L[15:8] % N_SEL
  - c = (L[7:0] ^ L[15:8]) % (N_GENES-1) + 1, so c is in 1..24
  - child[c*GENE_W-1:0] = parent a low bits
  - child[IND_W-1:c*GENE_W] = parent b high bits
  - a==b is legal; the child is then a copy of that parent.
- All modulo operations have constant divisors and resolve combinationally. No multi-cycle arithmetic.
- The crossover boundary always falls on a GENE_W multiple. Each child contains at least one gene from each parent.

Optional Feature:
- Macro: BREED_MUTATION_EN.
- Defined: after crossover, if L[3:0]==4'd0, invert child bit m = (L[11:4] ^ L[15:8]) % IND_W before writing the child. Elite slots are never mutated.
- Undefined: no mutation logic is present; the child is the pure crossover result. Latency is identical in both builds.

Test Plan:
- Elitism: sel_pop slot i = {25{6'(i+1)}}, seed=16'h1234, start -> pop_out slots 0..9 equal the parents bit-exact. done pulses exactly once, 42 cycles after start.
- Crossover shape: parents alternate all-zeros (even i) / all-ones (odd i), seed=16'h00FF -> every child 10..49 is either uniform or a single 0/1 transition at a bit index that is a multiple of 6 in 6..144. Children match a golden model of the LFSR/a/b/c equations.
- Seed zero: seed=0 -> output identical to a run with seed=16'hACE1.
- Start while busy: pulse start again at cycles 5 and 20 of a pass -> ignored. done still at cycle 42; pop_out matches the single-start golden output.
- Reset mid-pass: assert rst at BREED cycle 15 -> next cycle pop_out=0, busy=0, done=0. A fresh start with the same seed reproduces the golden result.
- Mutation (BREED_MUTATION_EN defined): all parents all-zeros, seed=16'hACE1 -> children equal zero except single-bit flips exactly at the cycles where L[3:0]==0, at the bit m the model predicts. Without the macro, all 50 slots are zero.
